// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, arithmetic helpers and twiddle generation for the R2SDF FFT
//
// Purpose : common definitions for the fixed-point R2SDF stage and its twiddle ROM.
//   stage_state_e - FILL/RUN state of a stage
//   LATENCY       - input-to-output latency of one stage in clocks
//   round_shift   - arithmetic right shift with round-half-up
//   saturate      - clamp a value to a signed width
//   twiddle_val   - integer twiddle coefficient, evaluated with constant arguments
package fft_pkg;

  localparam int LATENCY = 2;
  localparam real PI = 3.14159265358979323846;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } stage_state_e;

  // (x + 2^(sh-1)) >>> sh; sh = 0 passes x through untouched.
  function automatic longint round_shift(input longint x, input int sh);
    if (sh <= 0) return x;
    return (x + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic longint saturate(input longint x, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // round(cos|sin(2*pi*m/2^n) * (2^(tw-1)-1)), halves rounded away from zero.
  // Full scale is 2^(tw-1)-1 so that +1.0 never wraps to the negative rail.
  function automatic int twiddle_val(input int m, input int n, input int tw, input bit want_sin);
    real ang;
    real v;
    real s;
    ang = 2.0 * PI * real'(m) / (2.0 ** n);
    v   = want_sin ? $sin(ang) : $cos(ang);
    s   = v * ((2.0 ** (tw - 1)) - 1.0);
    return (s >= 0.0) ? $rtoi(s + 0.5) : $rtoi(s - 0.5);
  endfunction

endpackage

// File: rtl/r2sdf_twiddle_rom.sv
// rtl/r2sdf_twiddle_rom.sv - registered twiddle lookup for one R2SDF stage
//
// Purpose : maps position k to W^(k*2^(STAGE-1)) with one clock of latency so the
//           coefficient lines up with the butterfly register of the stage.
// Ports   : clk, rst_n  - clock, synchronous active-low reset
//           en          - advance (one accepted input sample)
//           k           - position inside the half period
//           inverse     - 1 selects the conjugate twiddle
//           wr, wi      - registered twiddle real/imag, Q1.(TW-1)
module r2sdf_twiddle_rom
  import fft_pkg::*;
#(
  parameter int N     = 3,
  parameter int STAGE = 1,
  parameter int TW    = 16,
  localparam int D    = 1 << (N - STAGE),
  localparam int KW   = (N - STAGE > 0) ? (N - STAGE) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [KW-1:0]        k,
  input  logic                 inverse,
  output logic signed [TW-1:0] wr,
  output logic signed [TW-1:0] wi
);

  logic signed [TW-1:0] cos_tab [D];
  logic signed [TW-1:0] sin_tab [D];

  // Constant arguments only: these fold to a fixed table.
  for (genvar i = 0; i < D; i++) begin : g_tab
    assign cos_tab[i] = TW'(twiddle_val(i << (STAGE - 1), N, TW, 1'b0));
    assign sin_tab[i] = TW'(twiddle_val(i << (STAGE - 1), N, TW, 1'b1));
  end

  // Forward W = cos - j*sin; inverse uses the conjugate cos + j*sin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr <= '0;
      wi <= '0;
    end else if (en) begin
      wr <= cos_tab[k];
      wi <= inverse ? sin_tab[k] : -sin_tab[k];
    end
  end

endmodule

// File: rtl/r2sdf_stage_fx.sv
// rtl/r2sdf_stage_fx.sv - fixed-point radix-2 single-path delay-feedback DIF FFT stage
//
// Purpose : one streaming R2SDF stage; cascade N of them for a 2^N-point FFT.
// Ports   : clk, rst_n         - clock, synchronous active-low reset
//           in_valid, in_sof   - input qualifier, first sample of a frame
//           in_inverse         - conjugate twiddles, latched with in_sof
//           in_re, in_im       - input sample, DW bits signed
//           out_valid, out_sof - output qualifier, first output of a frame
//           out_re, out_im     - output sample, OW bits signed
//           sync_err           - one-cycle pulse on an off-boundary in_sof
module r2sdf_stage_fx
  import fft_pkg::*;
#(
  parameter int N     = 3,
  parameter int STAGE = 1,
  parameter int DW    = 16,
  parameter int TW    = 16,
  parameter int SCALE = 1,
  localparam int OW   = (SCALE != 0) ? DW : DW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic                 in_inverse,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic                 sync_err
);

  localparam int D        = 1 << (N - STAGE);
  localparam int KW       = (N - STAGE > 0) ? (N - STAGE) : 1;
  localparam int SHIFT_BF = (SCALE != 0) ? 1 : 0;
  localparam logic [N-1:0] CNT_LAST_FILL = N'(D - 1);
  localparam logic [N-1:0] CNT_D         = N'(D);
  localparam logic [N-1:0] K_MASK        = N'(D - 1);

  stage_state_e state_q, state_d;
  logic [N-1:0]  cnt_q, cnt_eff;
  logic          inv_q, sof_pend_q;
  logic          sof_hit, resync, fill_done, run_eff, h, use_mult, sof_mark;
  logic [KW-1:0] k;

  logic signed [OW-1:0] fifo_re [D];
  logic signed [OW-1:0] fifo_im [D];
  logic signed [OW-1:0] head_re, head_im, ext_re, ext_im;
  logic signed [OW-1:0] bf_next_re, bf_next_im, push_re, push_im;
  longint               sum_re, sum_im, diff_re, diff_im, prod_re, prod_im;
  logic signed [OW-1:0] mul_re, mul_im;

  logic                 v1, v1_raw, sof1, bf_mul;
  logic signed [OW-1:0] bf_re, bf_im;
  logic signed [TW-1:0] wr, wi;

  // Control: an in_sof forces the sample to position 0 of a new frame in the same cycle.
  always_comb begin
    sof_hit   = in_valid && in_sof;
    resync    = sof_hit && (cnt_q != '0);
    cnt_eff   = sof_hit ? '0 : cnt_q;
    h         = cnt_eff[N-STAGE];
    k         = KW'(cnt_eff & K_MASK);
    fill_done = in_valid && (cnt_eff == CNT_LAST_FILL);
    run_eff   = (state_q == ST_RUN) && !resync;
    use_mult  = !h && (k != '0);
    sof_mark  = in_valid && run_eff && (sof_hit || sof_pend_q) && (cnt_eff == CNT_D);
    state_d   = state_q;
    case (state_q)
      ST_FILL: if (fill_done) state_d = ST_RUN;
      ST_RUN:  if (resync) state_d = fill_done ? ST_RUN : ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  // Butterfly and multiplier arithmetic, all in 64-bit before saturation.
  always_comb begin
    head_re    = fifo_re[D-1];
    head_im    = fifo_im[D-1];
    ext_re     = OW'(in_re);
    ext_im     = OW'(in_im);
    sum_re     = saturate(round_shift(longint'(head_re) + longint'(ext_re), SHIFT_BF), OW);
    sum_im     = saturate(round_shift(longint'(head_im) + longint'(ext_im), SHIFT_BF), OW);
    // a-b can exceed the signed range even after halving (max - min), hence the clamp.
    diff_re    = saturate(round_shift(longint'(head_re) - longint'(ext_re), SHIFT_BF), OW);
    diff_im    = saturate(round_shift(longint'(head_im) - longint'(ext_im), SHIFT_BF), OW);
    bf_next_re = h ? OW'(sum_re) : head_re;
    bf_next_im = h ? OW'(sum_im) : head_im;
    push_re    = h ? OW'(diff_re) : ext_re;
    push_im    = h ? OW'(diff_im) : ext_im;
    prod_re    = longint'(bf_re) * longint'(wr) - longint'(bf_im) * longint'(wi);
    prod_im    = longint'(bf_re) * longint'(wi) + longint'(bf_im) * longint'(wr);
    mul_re     = OW'(saturate(round_shift(prod_re, TW - 1), OW));
    mul_im     = OW'(saturate(round_shift(prod_im, TW - 1), OW));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      inv_q      <= 1'b0;
      sof_pend_q <= 1'b0;
      sync_err   <= 1'b0;
      v1         <= 1'b0;
      v1_raw     <= 1'b0;
      sof1       <= 1'b0;
      bf_mul     <= 1'b0;
      bf_re      <= '0;
      bf_im      <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
    end else begin
      state_q   <= state_d;
      sync_err  <= resync;
      v1        <= in_valid && run_eff;
      v1_raw    <= in_valid;
      sof1      <= sof_mark;
      out_valid <= v1;
      out_sof   <= sof1;
      if (in_valid) begin
        cnt_q  <= cnt_eff + N'(1);
        bf_re  <= bf_next_re;
        bf_im  <= bf_next_im;
        bf_mul <= use_mult;
      end
      if (sof_hit) begin
        inv_q <= in_inverse;
      end
      if (sof_hit) begin
        sof_pend_q <= 1'b1;
      end else if (sof_mark) begin
        sof_pend_q <= 1'b0;
      end
      if (v1_raw) begin
        out_re <= bf_mul ? mul_re : bf_re;
        out_im <= bf_mul ? mul_im : bf_im;
      end
    end
  end

  // Delay line: index 0 is the newest entry, D-1 the head.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      fifo_re[0] <= push_re;
      fifo_im[0] <= push_im;
      for (int i = 1; i < D; i++) begin
        fifo_re[i] <= fifo_re[i-1];
        fifo_im[i] <= fifo_im[i-1];
      end
    end
  end

  r2sdf_twiddle_rom #(
    .N     (N),
    .STAGE (STAGE),
    .TW    (TW)
  ) u_rom (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (in_valid),
    .k       (k),
    .inverse (inv_q),
    .wr      (wr),
    .wi      (wi)
  );

endmodule

// File: tb/tb_r2sdf_stage_fx.sv
// tb/tb_r2sdf_stage_fx.sv - scoreboard bench for r2sdf_stage_fx (N=3, STAGE=1, SCALE=1)
module tb_r2sdf_stage_fx;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_sof = 1'b0;
  logic               in_inverse = 1'b0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;
  logic               out_valid, out_sof, sync_err;
  logic signed [15:0] out_re, out_im;

  r2sdf_stage_fx #(
    .N(3), .STAGE(1), .DW(16), .TW(16), .SCALE(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_inverse (in_inverse),
    .in_re      (in_re),
    .in_im      (in_im),
    .out_valid  (out_valid),
    .out_sof    (out_sof),
    .out_re     (out_re),
    .out_im     (out_im),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int re;
    int im;
    bit sof;
    int at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   serr_cnt = 0;

  int vin_re [12];
  int vin_im [12];
  int vexp_re [8];
  int vexp_im [8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per presented output, including its arrival cycle.
  always @(negedge clk) begin
    if (rst_n && sync_err) serr_cnt++;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_re", out_re, e.re);
        check("out_im", out_im, e.im);
        check("out_sof", out_sof, e.sof);
        check("out_cycle", cyc, e.at);
      end
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    serr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sof   = 1'($urandom);
      in_re    = 16'($urandom);
      in_im    = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sof", out_sof, 0);
      check("rst_sync_err", sync_err, 0);
      check("rst_out_re", out_re, 0);
      check("rst_out_im", out_im, 0);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst_n    = 1'b1;
  endtask

  // Drives one accepted sample; its output (if any) is due two sampled cycles later.
  task automatic feed(input int re, input int im, input bit sof, input bit inv,
                      input bit exp_on, input int ere, input int eim, input bit esof,
                      input bit gap);
    in_valid   = 1'b1;
    in_sof     = sof;
    in_inverse = inv;
    in_re      = 16'(re);
    in_im      = 16'(im);
    if (exp_on) sb.push_back('{re: ere, im: eim, sof: esof, at: cyc + 2});
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (gap) @(negedge clk);
  endtask

  // Reset, optional DC pre-stream of 'pre' samples, then the aligned 12-sample frame.
  task automatic run_frame(input string tname, input bit inv, input bit gap, input int pre);
    do_reset();
    for (int i = 0; i < pre; i++) begin
      feed(1000, 0, i == 0, 1'b0, i >= 4, (i < 8) ? 1000 : 0, 0, i == 4, gap);
    end
    for (int i = 0; i < 12; i++) begin
      if (i >= 4) feed(vin_re[i], vin_im[i], i == 0, inv, 1'b1, vexp_re[i-4], vexp_im[i-4], i == 4, gap);
      else        feed(vin_re[i], vin_im[i], i == 0, inv, 1'b0, 0, 0, 1'b0, gap);
    end
    for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
    check({tname, "_drained"}, sb.size(), 0);
    check({tname, "_sync_err_pulses"}, serr_cnt, (pre % 8 != 0) ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(negedge clk);

    // 1: reset behaviour, first output two cycles after the 5th valid input
    vin_re  = '{-1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000, 0, 0, 0, 0};
    vin_im  = '{500, 500, 500, 500, 500, 500, 500, 500, 0, 0, 0, 0};
    vexp_re = '{-1000, -1000, -1000, -1000, 0, 0, 0, 0};
    vexp_im = '{500, 500, 500, 500, 0, 0, 0, 0};
    run_frame("t1_const", 1'b0, 1'b0, 0);

    // 2: impulse
    vin_re  = '{1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vin_im  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vexp_re = '{500, 0, 0, 0, 500, 0, 0, 0};
    vexp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame("t2_impulse", 1'b0, 1'b0, 0);

    // 3: DC
    vin_re  = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 0, 0, 0, 0};
    vexp_re = '{1000, 1000, 1000, 1000, 0, 0, 0, 0};
    run_frame("t3_dc", 1'b0, 1'b0, 0);

    // 5: DC with a bubble after every sample
    run_frame("t5_dc_bubbles", 1'b0, 1'b1, 0);

    // 6: in_sof at cnt=3 of a running stream, then an aligned DC frame
    run_frame("t6_resync", 1'b0, 1'b0, 11);

    // 4: x1 = 1000 forward and inverse (W^1 = 0.7071 -/+ j0.7071)
    vin_re  = '{0, 1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vexp_re = '{0, 500, 0, 0, 0, 354, 0, 0};
    vexp_im = '{0, 0, 0, 0, 0, -354, 0, 0};
    run_frame("t4_fwd", 1'b0, 1'b0, 0);
    vexp_im = '{0, 0, 0, 0, 0, 354, 0, 0};
    run_frame("t4_inv", 1'b1, 1'b0, 0);

    // x1 = j1000 forward: 500j * (0.7071 - j0.7071) = 354 + j354
    vin_re  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vin_im  = '{0, 1000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vexp_re = '{0, 0, 0, 0, 0, 354, 0, 0};
    vexp_im = '{0, 500, 0, 0, 0, 354, 0, 0};
    run_frame("t4_imag_fwd", 1'b0, 1'b0, 0);

    // x2 = 1000 forward: W^2 = -j
    vin_re  = '{0, 0, 1000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vin_im  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vexp_re = '{0, 0, 500, 0, 0, 0, 0, 0};
    vexp_im = '{0, 0, 0, 0, 0, 0, -500, 0};
    run_frame("t4_k2_fwd", 1'b0, 1'b0, 0);

    // x3 = 1000 inverse: conj(W^3) = -0.7071 + j0.7071
    vin_re  = '{0, 0, 0, 1000, 0, 0, 0, 0, 0, 0, 0, 0};
    vexp_re = '{0, 0, 0, 500, 0, 0, 0, -354};
    vexp_im = '{0, 0, 0, 0, 0, 0, 0, 354};
    run_frame("t4_k3_inv", 1'b1, 1'b0, 0);

    // a-b overflow after halving: (32767 - -32768 + 1) >>> 1 = 32768 clamps to 32767
    vin_re  = '{32767, 0, 0, 0, -32768, 0, 0, 0, 0, 0, 0, 0};
    vexp_re = '{0, 0, 0, 0, 32767, 0, 0, 0};
    vexp_im = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame("t7_saturate", 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/r2sdf_stage_fx.md
# r2sdf_stage_fx

Fixed-point, synthesizable radix-2 single-path delay-feedback (R2SDF) decimation-in-frequency FFT stage. It streams one complex sample per valid cycle, tolerates bubbles, and supports forward and inverse transforms selected per frame. `N` of these stages are cascaded (`STAGE`=1..N) to form a 2^N-point pipelined FFT. Input is in natural order; the final output is in bit-reversed order.

## Interface
- `N`, 3: log2 of FFT size.
- `STAGE`, 1: stage index, 1..N. Delay `D` = 2^(N-STAGE).
- `DW`, 16: input real/imag width, signed two's complement.
- `TW`, 16: twiddle width, signed Q1.(TW-1).
- `SCALE`, 1: 1 = halve the butterfly result, so output width `OW`=`DW`. 0 = no scaling, so `OW`=`DW`+1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `in_valid` in 1: input sample qualifier.
- `in_sof` in 1: first sample of a 2^N frame. Only meaningful when `in_valid`=1.
- `in_inverse` in 1: conjugate twiddles. Sampled only with `in_sof`&`in_valid`.
- `in_re`, `in_im` in DW: input sample.
- `out_valid` out 1: output qualifier.
- `out_sof` out 1: first output of a frame.
- `out_re`, `out_im` out OW: output sample.
- `sync_err` out 1: one-cycle pulse when `in_sof` arrives off-boundary.

## Operation
- Sample counter `cnt` is N bits and advances only on `in_valid`. Phase bit `h`=`cnt[N-STAGE]`; position `k`=`cnt[N-STAGE-1:0]` (k=0 when STAGE=N).
- Delay line: D-entry FIFO of OW-wide complex values, advanced only on `in_valid`.
- **h=0 (fill):** push the input (sign-extended to OW) into the FIFO. Output = FIFO head multiplied by W^(k·2^(STAGE-1)), where W=exp(-j2π/2^N), or its conjugate if inverse is latched.
- **h=1 (butterfly):** with `a` = FIFO head and `b` = input:
  - output `a+b`, twiddle bypassed;
  - push `a-b` into the FIFO;
  - if SCALE=1, both results are (x+1)>>>1.
- k=0 always bypasses the multiplier, because 1.0 is not representable.
- Multiplier: full-precision complex product, then rounding (+2^(TW-2))>>>(TW-1), then saturation to OW.
- Twiddle ROM entry: round(cos·(2^(TW-1)-1)) and round(sin·(2^(TW-1)-1)).
- States:
  - FILL: after reset or resync, until D valid inputs have been accepted. Outputs are suppressed.
  - RUN: thereafter.
- `in_sof` with `in_valid`:
  - If `cnt`=0: latch `in_inverse`; the frame starts normally.
  - If `cnt`≠0: force `cnt` to 0, return to FILL, pulse `sync_err`, latch `in_inverse`. The sample is taken as sample 0 of a new frame.
- Draining: the final D outputs of a stream emerge only as further valid inputs arrive. Upstream drains by feeding D zero samples.
- `out_sof` marks the `a+b` output for `cnt`=D of the frame's first period.

## Timing
- Latency is exactly 2 clocks from an accepted `in_valid` to its `out_valid`: one butterfly register plus one multiplier register. The bypass path is delayed equally.
- Bubbles propagate unchanged: `out_valid` = `in_valid` delayed 2, gated by RUN.
- Reset values: `out_valid`=0, `out_sof`=0, `sync_err`=0, `out_re`=`out_im`=0, `cnt`=0, state=FILL, inverse latch=0. FIFO contents are not reset.
- Reset mid-frame discards in-flight samples. No output appears until D valid inputs after `rst_n` deasserts.
- `cnt` wraps 2^N-1→0 with no gap.

## Structure
- Package `fft_pkg` holds:
  - rounding/saturation functions;
  - the elaboration-time twiddle generation function;
  - the latency localparam (2).
- Sub-module `r2sdf_twiddle_rom` (params N, STAGE, TW) maps k and inverse to registered cos/sin with 1-cycle latency, aligned with the butterfly register.

## Test plan
Parameters for tests 1–5: N=3, STAGE=1, DW=16, TW=16, SCALE=1.

1. Hold `rst_n`=0 for 3 cycles with random inputs and `in_valid`=1 → all outputs 0. Then release: the first `out_valid` appears 2 cycles after the 5th valid input.
2. Impulse: frame [1000,0,0,0,0,0,0,0], then 4 zeros → outputs 500,0,0,0,500,0,0,0 (real), imag 0. `out_sof` is on the first output.
3. DC: frame of 8×1000 plus 4 zeros → 1000,1000,1000,1000,0,0,0,0.
4. x1=1000, all others 0:
   - forward → 2nd output (500,0), 6th output (354,-354);
   - with `in_inverse`=1 → 6th output (354,+354).
5. Test 3 with `in_valid` toggling every other cycle → identical data sequence; `out_valid` spacing mirrors the input.
6. `in_sof` at `cnt`=3 → one `sync_err` pulse; the stream restarts in FILL and the following aligned DC frame gives test 3's result.
